// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter feeding a single register-file write port.
// Round-robin on ties, one-cycle output stage, X31 writes consumed but dropped, read-port forwarding.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        freeze,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_addr,
    input  logic [63:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_addr,
    input  logic [63:0] req1_data,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [63:0] wd3,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic        fwd1_en,
    output logic [63:0] fwd1_data,
    output logic        fwd2_en,
    output logic [63:0] fwd2_data,
    output logic [15:0] conflict_cnt,
    output logic [7:0]  drop_cnt
);

    localparam logic [4:0] ADDR_X31 = 5'd31;

    logic        last_grant;
    logic        grant0;
    logic        grant1;
    logic        take0;
    logic        take1;
    logic        xfer;
    logic [4:0]  sel_addr;
    logic [63:0] sel_data;

    always_comb begin
        // On a tie the requester opposite the previous winner gets the port.
        grant0     = req0_valid && (!req1_valid || last_grant);
        grant1     = req1_valid && (!req0_valid || !last_grant);
        req0_ready = grant0 && !freeze && !reset;
        req1_ready = grant1 && !freeze && !reset;
        take0      = req0_valid && req0_ready;
        take1      = req1_valid && req1_ready;
        xfer       = take0 || take1;
        sel_addr   = take1 ? req1_addr : req0_addr;
        sel_data   = take1 ? req1_data : req0_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant   <= 1'b1;
            we3          <= 1'b0;
            wa3          <= 5'd0;
            wd3          <= 64'd0;
            conflict_cnt <= 16'd0;
            drop_cnt     <= 8'd0;
        end else begin
            if (xfer) begin
                last_grant <= take1;
            end

            if (xfer && sel_addr != ADDR_X31) begin
                we3 <= 1'b1;
                wa3 <= sel_addr;
                wd3 <= sel_data;
            end else begin
                we3 <= 1'b0;
                wa3 <= 5'd0;
                wd3 <= 64'd0;
            end

            if (xfer && sel_addr == ADDR_X31 && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end

            if (req0_valid && req1_valid && !freeze && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        fwd1_en   = we3 && (wa3 == ra1) && (ra1 != ADDR_X31);
        fwd2_en   = we3 && (wa3 == ra2) && (ra2 != ADDR_X31);
        fwd1_data = fwd1_en ? wd3 : 64'd0;
        fwd2_data = fwd2_en ? wd3 : 64'd0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbiter.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset, freeze;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]  req0_addr, req1_addr, wa3, ra1, ra2;
    logic [63:0] req0_data, req1_data, wd3, fwd1_data, fwd2_data;
    logic        we3, fwd1_en, fwd2_en;
    logic [15:0] conflict_cnt;
    logic [7:0]  drop_cnt;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int          m_last;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [63:0] m_wd;
    int          m_conf;
    int          m_drop;

    // Last observed combinational values, for directed checks
    logic obs_r0, obs_r1, obs_f1, obs_f2;
    logic [63:0] obs_f1d;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .ra2(ra2),
        .fwd1_en(fwd1_en), .fwd1_data(fwd1_data), .fwd2_en(fwd2_en), .fwd2_data(fwd2_data),
        .conflict_cnt(conflict_cnt), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // -1 = nobody accepted this cycle
    function automatic int winner(input logic v0, input logic v1, input logic frz, input logic rst);
        if (rst || frz) return -1;
        if (v0 && v1)   return 1 - m_last;
        if (v0)         return 0;
        if (v1)         return 1;
        return -1;
    endfunction

    task automatic cycle(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                         input logic frz, input logic rst, input logic [4:0] r1, input logic [4:0] r2);
        int w;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic e1, e2;
        reset = rst; freeze = frz;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        ra1 = r1; ra2 = r2;
        #1;
        w = winner(v0, v1, frz, rst);
        e1 = m_we && (m_wa == r1) && (r1 != 5'd31);
        e2 = m_we && (m_wa == r2) && (r2 != 5'd31);
        chk("req0_ready", req0_ready, w == 0);
        chk("req1_ready", req1_ready, w == 1);
        chk("fwd1_en", fwd1_en, e1);
        chk("fwd2_en", fwd2_en, e2);
        chk("fwd1_data", fwd1_data, e1 ? m_wd : 64'd0);
        chk("fwd2_data", fwd2_data, e2 ? m_wd : 64'd0);
        obs_r0 = req0_ready; obs_r1 = req1_ready;
        obs_f1 = fwd1_en; obs_f2 = fwd2_en; obs_f1d = fwd1_data;
        @(posedge clk);
        #1;
        if (rst) begin
            m_last = 1; m_we = 0; m_wa = 0; m_wd = 0; m_conf = 0; m_drop = 0;
        end else begin
            if (v0 && v1 && !frz && m_conf < 65535) m_conf++;
            m_we = 0; m_wa = 0; m_wd = 0;
            if (w >= 0) begin
                wa = (w == 0) ? a0 : a1;
                wd = (w == 0) ? d0 : d1;
                m_last = w;
                if (wa == 5'd31) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    m_we = 1; m_wa = wa; m_wd = wd;
                end
            end
        end
        chk("we3", we3, m_we);
        chk("wa3", wa3, m_wa);
        chk("wd3", wd3, m_wd);
        chk("conflict_cnt", conflict_cnt, m_conf);
        chk("drop_cnt", drop_cnt, m_drop);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0);
    endtask

    initial begin
        int c0;
        m_last = 1; m_we = 0; m_wa = 0; m_wd = 0; m_conf = 0; m_drop = 0;
        reset = 1; freeze = 0;
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
        ra1 = 0; ra2 = 0;

        // Reset state
        cycle(1, 5'd3, 64'h1, 1, 5'd4, 64'h2, 0, 1, 5'd0, 5'd0);
        chk("rst_ready0", obs_r0, 1'b0);
        chk("rst_ready1", obs_r1, 1'b0);
        do_reset();
        chk("rst_we3", we3, 1'b0);
        chk("rst_conflict", conflict_cnt, 16'd0);

        // Single req0 write, one cycle latency, single-cycle pulse
        cycle(1, 5'd5, 64'hAA, 0, 0, 0, 0, 0, 5'd0, 5'd0);
        chk("single_ready0", obs_r0, 1'b1);
        chk("single_we3", we3, 1'b1);
        chk("single_wa3", wa3, 5'd5);
        chk("single_wd3", wd3, 64'hAA);
        idle();
        chk("single_drain", we3, 1'b0);

        // Continuous tie after reset alternates starting with req0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1, 5'd10, 64'h100 + i, 1, 5'd11, 64'h200 + i, 0, 0, 5'd0, 5'd0);
            chk("tie_grant0", obs_r0, (i % 2) == 0);
            chk("tie_grant1", obs_r1, (i % 2) == 1);
        end
        chk("tie_conflict4", conflict_cnt, 16'd4);
        idle();

        // X31 write from req1 is consumed and dropped
        do_reset();
        cycle(0, 0, 0, 1, 5'd31, 64'hDEAD, 0, 0, 5'd0, 5'd0);
        chk("x31_ready1", obs_r1, 1'b1);
        chk("x31_we3", we3, 1'b0);
        chk("x31_drop", drop_cnt, 8'd1);

        // Forwarding to read port 1 only
        cycle(1, 5'd7, 64'h1234, 0, 0, 0, 0, 0, 5'd0, 5'd0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd8);
        chk("fwd_en1", obs_f1, 1'b1);
        chk("fwd_data1", obs_f1d, 64'h1234);
        chk("fwd_en2", obs_f2, 1'b0);

        // Freeze: in-flight write still issues, no grants, no conflict counting
        c0 = int'(conflict_cnt);
        cycle(1, 5'd12, 64'h55, 0, 0, 0, 0, 0, 5'd12, 5'd0);
        cycle(1, 5'd13, 64'h66, 1, 5'd14, 64'h77, 1, 0, 5'd12, 5'd0);
        chk("frz_ready0", obs_r0, 1'b0);
        chk("frz_ready1", obs_r1, 1'b0);
        chk("frz_inflight_fwd", obs_f1, 1'b1);
        chk("frz_we3_drained", we3, 1'b0);
        chk("frz_conflict", conflict_cnt, c0[15:0]);
        cycle(1, 5'd13, 64'h66, 1, 5'd14, 64'h77, 1, 0, 5'd0, 5'd0);

        // Same address from both requesters on consecutive grants: both written in order
        cycle(1, 5'd9, 64'hA0, 1, 5'd9, 64'hB0, 0, 0, 5'd0, 5'd0);
        cycle(1, 5'd9, 64'hA0, 1, 5'd9, 64'hB0, 0, 0, 5'd0, 5'd0);
        idle();

        // Reset right after an acceptance discards the latched write
        cycle(1, 5'd6, 64'h99, 0, 0, 0, 0, 0, 5'd0, 5'd0);
        do_reset();
        chk("rst_discard_we3", we3, 1'b0);
        chk("rst_discard_drop", drop_cnt, 8'd0);
        cycle(1, 5'd2, 64'h1, 1, 5'd3, 64'h2, 0, 0, 5'd0, 5'd0);
        chk("rst_first_tie", obs_r0, 1'b1);

        // drop_cnt saturation
        for (int i = 0; i < 260; i++) cycle(1, 5'd31, 64'h0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
        chk("drop_sat", drop_cnt, 8'hFF);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] a0, a1, r1, r2;
            a0 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 9));
            a1 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 9));
            r1 = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 9));
            r2 = 5'($urandom_range(0, 9));
            cycle(1'($urandom_range(0, 1)), a0, {$urandom, $urandom},
                  1'($urandom_range(0, 1)), a1, {$urandom, $urandom},
                  $urandom_range(0, 5) == 0, $urandom_range(0, 60) == 0, r1, r2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The module SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 The module SHALL have ports: freeze  in  1  pipeline hold; no acceptance while high.
REQ-003 The module SHALL have ports: req0_valid  in  1; req0_ready  out  1; req0_addr  in  5; req0_data  in  64  (ALU writeback requester).
REQ-004 The module SHALL have ports: req1_valid  in  1; req1_ready  out  1; req1_addr  in  5; req1_data  in  64  (load writeback requester).
REQ-005 The module SHALL have ports: we3  out  1; wa3  out  5; wd3  out  64  (register-file write port).
REQ-006 The module SHALL have ports: ra1  in  5; ra2  in  5  (current read addresses); fwd1_en  out  1; fwd1_data  out  64; fwd2_en  out  1; fwd2_data  out  64.
REQ-007 The module SHALL have ports: conflict_cnt  out  16  (saturating count of arbitration-loss cycles); drop_cnt  out  8  (saturating count of X31 writes dropped).

Function
REQ-008 The module SHALL accept at most one request per cycle; a transfer occurs when reqN_valid and reqN_ready are both high at a rising edge.
REQ-009 reqN_ready SHALL be combinational: low whenever freeze=1; otherwise high for the granted requester only.
REQ-010 The module SHALL grant a lone valid requester unconditionally.
REQ-011 When both requesters are valid, the module SHALL grant the requester opposite last_grant.
REQ-012 last_grant SHALL be a 1-bit register updated to the index of the accepted requester on every transfer.
REQ-013 last_grant SHALL reset to 1, so req0 wins the first tie.
REQ-014 An accepted request SHALL be latched into a one-entry output stage.
REQ-015 A request accepted at edge N SHALL be driven on we3/wa3/wd3 during cycle N+1 for exactly one cycle; latency is 1.
REQ-016 The output stage SHALL clear to we3=0 in any cycle following no transfer.
REQ-017 An accepted request with addr=31 SHALL be consumed (ready asserted normally) but SHALL produce we3=0 in cycle N+1.
REQ-018 An accepted request with addr=31 SHALL increment drop_cnt, saturating at 255.
REQ-019 While we3=1, wa3 and wd3 SHALL hold the latched address and data; while we3=0 they SHALL hold 0.
REQ-020 fwd1_en SHALL be high when we3=1 and wa3==ra1 and ra1!=31; fwd1_data SHALL equal wd3 when fwd1_en is high, else 0.
REQ-021 fwd2_en and fwd2_data SHALL follow REQ-020 with ra2 in place of ra1.
REQ-022 conflict_cnt SHALL increment once per cycle where req0_valid=1, req1_valid=1 and freeze=0, saturating at 65535.
REQ-023 Cycles with freeze=1 SHALL NOT count toward conflict_cnt.
REQ-024 freeze SHALL NOT cancel an already-latched write; a write latched at edge N SHALL still issue in cycle N+1 when freeze rises in cycle N+1.
REQ-025 Identical addresses from both requesters in consecutive grants SHALL both be written, in grant order, with no merging.

Reset
REQ-026 While reset=1 at a rising edge, the module SHALL clear we3, wa3, wd3, conflict_cnt and drop_cnt to 0 and set last_grant to 1.
REQ-027 While reset=1, both readies SHALL be 0 and no transfer SHALL occur.
REQ-028 A request latched in the edge preceding reset SHALL be discarded; we3=0 in the cycle after the reset edge.
REQ-029 fwd1_en and fwd2_en SHALL be 0 while we3=0.

Verification
REQ-030 Bench SHALL cover: req0 only, addr=5, data=0xAA -> req0_ready=1; next cycle we3=1, wa3=5, wd3=0xAA; following cycle we3=0.
REQ-031 Bench SHALL cover: both valid continuously for 4 cycles after reset -> grants req0, req1, req0, req1; conflict_cnt=4.
REQ-032 Bench SHALL cover: req1 with addr=31 -> req1_ready=1; next cycle we3=0; drop_cnt=1.
REQ-033 Bench SHALL cover: write addr=7, data=0x1234 accepted; next cycle ra1=7, ra2=8 -> fwd1_en=1, fwd1_data=0x1234, fwd2_en=0.
REQ-034 Bench SHALL cover: freeze=1 with both valid -> both readies 0, conflict_cnt unchanged, we3=0 after any in-flight write drains.
REQ-035 Bench SHALL cover: reset asserted the cycle after an acceptance -> we3=0, counters 0; first subsequent tie grants req0.
